addernet_psum_drain: RTL and testbench

//  Column-bottom drain stage below the AdderNet PE array; consumes o_PSUM of one column's bottom PE.

---
 rtl/addernet_psum_drain.sv | 81 ++++++++
 tb/tb_addernet_psum_drain.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/addernet_psum_drain.sv
// addernet_psum_drain: accumulates NUM_PASS partial sums per result into a saturating accumulator
// and queues finished results in a registered FIFO drained over valid/ready.
module addernet_psum_drain #(
    parameter int BIT_WIDTH_PSUM = 16,
    parameter int BIT_WIDTH_ACC  = 24,
    parameter int NUM_PASS       = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [BIT_WIDTH_PSUM-1:0]  i_PSUM,
    input  logic                       i_PSUMValid,
    input  logic                       i_Clear,
    output logic [BIT_WIDTH_ACC-1:0]   o_Data,
    output logic                       o_Valid,
    input  logic                       i_Ready,
    output logic [(NUM_PASS > 1 ? $clog2(NUM_PASS) : 1)-1:0] o_PassCnt,
    output logic                       o_Full,
    output logic                       o_Overflow
);
    localparam int CW = NUM_PASS > 1 ? $clog2(NUM_PASS) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = BIT_WIDTH_ACC + 1;

    logic [BIT_WIDTH_ACC-1:0] acc;
    logic [BIT_WIDTH_ACC-1:0] mem [FIFO_DEPTH];
    logic [CW-1:0]            cnt;
    logic [AW-1:0]            wr, rd;
    logic [AW:0]              count;
    logic [SW-1:0]            sum_raw;
    logic [BIT_WIDTH_ACC-1:0] sum;
    logic                     last, fire, pop, push, drop;

    always_comb begin
        fire    = i_PSUMValid && !i_Clear;
        last    = cnt == CW'(NUM_PASS - 1);
        sum_raw = (cnt == '0 ? '0 : {1'b0, acc}) + SW'(i_PSUM);
        sum     = sum_raw[BIT_WIDTH_ACC] ? '1 : sum_raw[BIT_WIDTH_ACC-1:0];
        o_Valid = count != '0;
        o_Full  = count == (AW+1)'(FIFO_DEPTH);
        o_Data  = o_Valid ? mem[rd] : '0;
        pop     = o_Valid && i_Ready;
        // a full FIFO still accepts the final pass if its head leaves in the same cycle
        push    = fire && last && (!o_Full || pop);
        drop    = fire && last && o_Full && !pop;
    end

    assign o_PassCnt = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            cnt        <= '0;
            wr         <= '0;
            rd         <= '0;
            count      <= '0;
            o_Overflow <= 1'b0;
        end else begin
            if (i_Clear) begin
                acc        <= '0;
                cnt        <= '0;
                o_Overflow <= 1'b0;
            end else if (i_PSUMValid) begin
                if (last) cnt <= '0;
                else begin
                    acc <= sum;
                    cnt <= cnt + 1'b1;
                end
                if (drop) o_Overflow <= 1'b1;
            end
            if (push) wr <= wr + 1'b1;
            if (pop) rd <= rd + 1'b1;
            if (push && !pop) count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr] <= sum;
    end
endmodule

// File: tb/tb_addernet_psum_drain.sv
// tb_addernet_psum_drain: scenario tasks plus randomized traffic checked against a queue-based model.
module tb_addernet_psum_drain;
    localparam int PW = 16;
    localparam int AW = 17;
    localparam int NP = 4;
    localparam int D  = 4;
    localparam longint MAXV = (longint'(1) << AW) - 1;

    logic          clk = 0, rst = 1;
    logic [PW-1:0] i_PSUM = '0;
    logic          i_PSUMValid = 0, i_Clear = 0, i_Ready = 0;
    logic [AW-1:0] o_Data;
    logic          o_Valid, o_Full, o_Overflow;
    logic [1:0]    o_PassCnt;

    int checks = 0, errors = 0;
    longint q[$];
    int m_cnt = 0;
    longint m_acc = 0;
    bit m_ovf = 0;

    addernet_psum_drain #(.BIT_WIDTH_PSUM(PW), .BIT_WIDTH_ACC(AW), .NUM_PASS(NP), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .i_PSUM(i_PSUM), .i_PSUMValid(i_PSUMValid), .i_Clear(i_Clear),
        .o_Data(o_Data), .o_Valid(o_Valid), .i_Ready(i_Ready), .o_PassCnt(o_PassCnt),
        .o_Full(o_Full), .o_Overflow(o_Overflow)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        q.delete();
        m_cnt = 0;
        m_acc = 0;
        m_ovf = 0;
    endtask

    // one clock: apply inputs, advance the model with the pre-edge state, settle 1 time unit after the edge
    task automatic cyc(input bit v, input logic [PW-1:0] p, input bit clr, input bit rdy);
        bit pop;
        longint s;
        i_PSUMValid = v;
        i_PSUM      = p;
        i_Clear     = clr;
        i_Ready     = rdy;
        @(posedge clk);
        pop = q.size() != 0 && rdy;
        if (pop) void'(q.pop_front());
        if (clr) begin
            m_cnt = 0;
            m_acc = 0;
            m_ovf = 0;
        end else if (v) begin
            s = (m_cnt == 0 ? 0 : m_acc) + longint'(p);
            if (s > MAXV) s = MAXV;
            if (m_cnt == NP - 1) begin
                m_cnt = 0;
                if (q.size() < D) q.push_back(s);
                else m_ovf = 1;
            end else begin
                m_acc = s;
                m_cnt++;
            end
        end
        #1;
    endtask

    function automatic longint head();
        return q.size() != 0 ? q[0] : 0;
    endfunction

    task automatic test_reset();
        checks++; if (o_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_Valid); end
        checks++; if (o_Data !== '0) begin errors++; $display("FAIL reset_data got %0h want 0", o_Data); end
        checks++; if (o_PassCnt !== 2'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", o_PassCnt); end
        checks++; if (o_Full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", o_Full); end
        checks++; if (o_Overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", o_Overflow); end
    endtask

    task automatic test_basic();
        int ps[4] = '{10, 20, 30, 40};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (o_PassCnt !== 2'(i)) begin errors++; $display("FAIL basic_cnt%0d got %0d want %0d", i, o_PassCnt, i); end
            checks++;
            if (o_Valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid%0d got %b want 0", i, o_Valid); end
            cyc(1, PW'(ps[i]), 0, 1);
        end
        checks++; if (o_PassCnt !== 2'd0) begin errors++; $display("FAIL basic_cnt_wrap got %0d want 0", o_PassCnt); end
        checks++;
        if (o_Valid !== 1'b1 || o_Data !== AW'(100)) begin
            errors++; $display("FAIL basic_result got v=%b d=%0d want v=1 d=100", o_Valid, o_Data);
        end
        cyc(0, 0, 0, 1);
        checks++; if (o_Valid !== 1'b0) begin errors++; $display("FAIL basic_pop got %b want 0", o_Valid); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) cyc(1, 16'hFFFF, 0, 0);
        checks++;
        if (o_Data !== 17'h1FFFF || o_Valid !== 1'b1) begin
            errors++; $display("FAIL saturation got v=%b d=%0h want v=1 d=1ffff", o_Valid, o_Data);
        end
        cyc(0, 0, 0, 1);
    endtask

    task automatic test_overflow();
        for (int r = 1; r <= 5; r++) begin
            cyc(1, PW'(r), 0, 0);
            for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0);
            if (r == 4) begin
                checks++;
                if (o_Full !== 1'b1 || o_Overflow !== 1'b0) begin
                    errors++; $display("FAIL ovf_full4 got full=%b ovf=%b want 1 0", o_Full, o_Overflow);
                end
            end
        end
        checks++;
        if (o_Full !== 1'b1 || o_Overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_drop got full=%b ovf=%b want 1 1", o_Full, o_Overflow);
        end
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (o_Valid !== 1'b1 || o_Data !== AW'(k)) begin
                errors++; $display("FAIL ovf_drain%0d got v=%b d=%0d want v=1 d=%0d", k, o_Valid, o_Data, k);
            end
            cyc(0, 0, 0, 1);
        end
        checks++;
        if (o_Valid !== 1'b0 || o_Overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_empty got v=%b ovf=%b want 0 1", o_Valid, o_Overflow);
        end
        cyc(0, 0, 1, 0);
        checks++; if (o_Overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", o_Overflow); end
    endtask

    task automatic test_full_push_pop();
        for (int r = 11; r <= 15; r++) begin
            for (int k = 0; k < 3; k++) cyc(1, (k == 0) ? PW'(r) : PW'(0), 0, 0);
            cyc(1, 0, 0, r == 15);
        end
        checks++;
        if (o_Full !== 1'b1 || o_Overflow !== 1'b0 || o_Data !== AW'(12)) begin
            errors++; $display("FAIL pushpop got full=%b ovf=%b d=%0d want 1 0 12", o_Full, o_Overflow, o_Data);
        end
        for (int k = 12; k <= 15; k++) begin
            checks++;
            if (o_Data !== AW'(k)) begin errors++; $display("FAIL pushpop_drain got %0d want %0d", o_Data, k); end
            cyc(0, 0, 0, 1);
        end
    endtask

    task automatic test_clear();
        cyc(1, 10, 0, 1);
        cyc(1, 20, 0, 1);
        cyc(1, 99, 1, 1);
        checks++; if (o_PassCnt !== 2'd0) begin errors++; $display("FAIL clear_cnt got %0d want 0", o_PassCnt); end
        checks++; if (o_Valid !== 1'b0) begin errors++; $display("FAIL clear_nopush got %b want 0", o_Valid); end
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);
        checks++;
        if (o_Valid !== 1'b1 || o_Data !== AW'(4)) begin
            errors++; $display("FAIL clear_result got v=%b d=%0d want v=1 d=4", o_Valid, o_Data);
        end
        cyc(0, 0, 0, 1);
    endtask

    task automatic test_reset_mid();
        for (int r = 0; r < 2; r++) for (int k = 0; k < 4; k++) cyc(1, 7, 0, 0);
        cyc(1, 3, 0, 0);
        cyc(1, 3, 0, 0);
        i_PSUMValid = 0;
        #2 rst = 1;
        model_reset();
        #1;
        checks++;
        if (o_Valid !== 1'b0 || o_PassCnt !== 2'd0 || o_Overflow !== 1'b0 || o_Full !== 1'b0) begin
            errors++; $display("FAIL async_reset got v=%b cnt=%0d ovf=%b full=%b want 0 0 0 0", o_Valid, o_PassCnt, o_Overflow, o_Full);
        end
        @(posedge clk);
        #1 rst = 0;
        for (int i = 0; i < 4; i++) cyc(1, 5, 0, 0);
        checks++;
        if (o_Valid !== 1'b1 || o_Data !== AW'(20)) begin
            errors++; $display("FAIL reset_result got v=%b d=%0d want v=1 d=20", o_Valid, o_Data);
        end
        cyc(0, 0, 0, 1);
    endtask

    task automatic test_random();
        logic [PW-1:0] p;
        for (int n = 0; n < 600; n++) begin
            p = ($urandom_range(0, 1) != 0) ? PW'($urandom_range(16'hC000, 16'hFFFF)) : PW'($urandom);
            cyc($urandom_range(0, 3) != 0, p, $urandom_range(0, 40) == 0, $urandom_range(0, 2) == 0);
            checks++;
            if ({o_Valid, o_Full, o_Overflow, o_PassCnt, o_Data} !==
                {q.size() != 0, q.size() == D, m_ovf, 2'(m_cnt), AW'(head())}) begin
                errors++;
                $display("FAIL random%0d got v=%b f=%b o=%b c=%0d d=%0h want v=%b f=%b o=%b c=%0d d=%0h", n,
                         o_Valid, o_Full, o_Overflow, o_PassCnt, o_Data,
                         q.size() != 0, q.size() == D, m_ovf, m_cnt, head());
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 0;
        test_basic();
        test_saturation();
        test_overflow();
        test_full_push_pop();
        test_clear();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
